// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine, C = A * B.
// One A column and one B row enter per beat; operands are skewed so that beat k meets
// in PE(r,c) after r+c+1 cycles. After a FLUSH of ROWS+COLS-1 cycles the grid holds C,
// which is drained one row per handshake.
module systolic_mm_engine #(
  parameter int unsigned ROWS   = 5,
  parameter int unsigned COLS   = 5,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned K_W    = 8,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   a_data,
  input  logic [COLS*DATA_W-1:0]   b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*ACC_W-1:0]    out_data,
  output logic [ROW_W-1:0]         out_row,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned FL_W = $clog2(ROWS + COLS);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(ROWS + COLS - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d, cnt_q, cnt_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             done_q, done_d;
  logic             clear_acc;
  logic             fire;

  assign in_ready = (state_q == StLoad);
  assign fire     = in_valid & in_ready;

  // Job sequencing: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    fl_d      = fl_q;
    row_d     = row_q;
    done_d    = 1'b0;
    clear_acc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_d       = k_len;
          cnt_d     = '0;
          fl_d      = '0;
          row_d     = '0;
          clear_acc = 1'b1;
          state_d   = (k_len == '0) ? StFlush : StLoad;
        end
      end
      StLoad: begin
        if (fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == k_q - 1'b1) state_d = StFlush;
        end
      end
      StFlush: begin
        if (fl_q == FL_LAST) begin
          fl_d    = '0;
          state_d = StDrain;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Skewed operands entering column 0 (A) and row 0 (B); bubbles inject zero/invalid
  logic [ROWS-1:0][DATA_W-1:0] a_sk;
  logic [ROWS-1:0]             a_sk_v;
  logic [COLS-1:0][DATA_W-1:0] b_sk;
  logic [COLS-1:0]             b_sk_v;

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_a_skew
    if (gr == 0) begin : g_direct
      assign a_sk[gr]   = fire ? a_data[gr*DATA_W +: DATA_W] : '0;
      assign a_sk_v[gr] = fire;
    end else begin : g_delay
      logic [DATA_W-1:0] d_q [gr];
      logic              v_q [gr];
      // Row gr of A is delayed gr cycles
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          for (int i = 0; i < gr; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= fire ? a_data[gr*DATA_W +: DATA_W] : '0;
          v_q[0] <= fire;
          for (int i = 1; i < gr; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign a_sk[gr]   = d_q[gr-1];
      assign a_sk_v[gr] = v_q[gr-1];
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_b_skew
    if (gc == 0) begin : g_direct
      assign b_sk[gc]   = fire ? b_data[gc*DATA_W +: DATA_W] : '0;
      assign b_sk_v[gc] = fire;
    end else begin : g_delay
      logic [DATA_W-1:0] d_q [gc];
      logic              v_q [gc];
      // Column gc of B is delayed gc cycles
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          for (int i = 0; i < gc; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= fire ? b_data[gc*DATA_W +: DATA_W] : '0;
          v_q[0] <= fire;
          for (int i = 1; i < gc; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign b_sk[gc]   = d_q[gc-1];
      assign b_sk_v[gc] = v_q[gc-1];
    end
  end

  // PE grid state
  logic signed [DATA_W-1:0]   a_q   [ROWS][COLS];
  logic signed [DATA_W-1:0]   b_q   [ROWS][COLS];
  logic                       a_v_q [ROWS][COLS];
  logic                       b_v_q [ROWS][COLS];
  logic signed [ACC_W-1:0]    acc_q [ROWS][COLS];
  logic signed [2*DATA_W-1:0] prod  [ROWS][COLS];

  // Full-precision signed product in every PE
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod[r][c] = (2*DATA_W)'(a_q[r][c]) * (2*DATA_W)'(b_q[r][c]);
      end
    end
  end

  // Operand forwarding (A eastward, B southward) and tagged accumulation
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          a_v_q[r][c] <= 1'b0;
          b_v_q[r][c] <= 1'b0;
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (c == 0) begin
            a_q[r][c]   <= a_sk[r];
            a_v_q[r][c] <= a_sk_v[r];
          end else begin
            a_q[r][c]   <= a_q[r][(c > 0) ? c - 1 : 0];
            a_v_q[r][c] <= a_v_q[r][(c > 0) ? c - 1 : 0];
          end
          if (r == 0) begin
            b_q[r][c]   <= b_sk[c];
            b_v_q[r][c] <= b_sk_v[c];
          end else begin
            b_q[r][c]   <= b_q[(r > 0) ? r - 1 : 0][c];
            b_v_q[r][c] <= b_v_q[(r > 0) ? r - 1 : 0][c];
          end
          if (clear_acc) begin
            acc_q[r][c] <= '0;
          end else if (a_v_q[r][c] && b_v_q[r][c]) begin
            acc_q[r][c] <= acc_q[r][c] + ACC_W'(prod[r][c]);
          end
        end
      end
    end
  end

  assign out_valid = (state_q == StDrain);
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == ROW_LAST);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  // Present the selected accumulator row while draining, zeros otherwise
  always_comb begin
    out_data = '0;
    if (state_q == StDrain) begin
      for (int c = 0; c < COLS; c++) begin
        out_data[c*ACC_W +: ACC_W] = acc_q[row_q][c];
      end
    end
  end

endmodule
